// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   SHOP_*    : 2-bit operation encodings presented on in_op
//   amt_width : shift-amount width (and pipeline depth) for a given data width
package shifter_pkg;

  localparam logic [1:0] SHOP_SLL = 2'b00;
  localparam logic [1:0] SHOP_ROR = 2'b01;
  localparam logic [1:0] SHOP_SRL = 2'b10;
  localparam logic [1:0] SHOP_SRA = 2'b11;

  // One pipeline level per amount bit, so this is also the stage count.
  function automatic int amt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One level of the barrel shifter: conditional shift by 2**LEVEL plus its pipeline register.
// Latency: 1 cycle (register at the output of the level mux).
// Backpressure: up_ready = !valid || down_ready; the register holds while downstream stalls.
//
// Ports:
//   clk, resetn, flush       : clock, async active-low reset, sync pipeline discard
//   up_valid/up_ready        : handshake with the previous level (or the block input)
//   up_data/amt/op/tag       : operation arriving from the previous level
//   down_ready               : ready of the next level (or out_ready for the last level)
//   valid/data/amt/op/tag    : registered contents of this level
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int LEVEL      = 0,
  localparam int AMT_W     = amt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic [AMT_W-1:0]      up_amt,
  input  logic [1:0]            up_op,
  input  logic [TAG_WIDTH-1:0]  up_tag,
  input  logic                  down_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [AMT_W-1:0]      amt,
  output logic [1:0]            op,
  output logic [TAG_WIDTH-1:0]  tag
);

  localparam int SHIFT = 1 << LEVEL;

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] level_out;

  // SRA fills with the current MSB; earlier levels already replicated the
  // sign bit, so this is always the original sign.
  always_comb begin
    shifted = up_data;
    case (up_op)
      SHOP_SLL: shifted = {up_data[DATA_WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
      SHOP_SRL: shifted = {{SHIFT{1'b0}}, up_data[DATA_WIDTH-1:SHIFT]};
      SHOP_SRA: shifted = {{SHIFT{up_data[DATA_WIDTH-1]}}, up_data[DATA_WIDTH-1:SHIFT]};
      default:  shifted = {up_data[SHIFT-1:0], up_data[DATA_WIDTH-1:SHIFT]};
    endcase
    level_out = up_amt[LEVEL] ? shifted : up_data;
  end

  // Ready chain: an empty level always accepts, a full one only if it drains.
  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
      amt   <= '0;
      op    <= '0;
      tag   <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (up_ready) begin
        valid <= up_valid;
      end
      // Payload only moves on a real transfer; after a flush it may be stale.
      if (up_ready && up_valid) begin
        data <= level_out;
        amt  <= up_amt;
        op   <= up_op;
        tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Fully pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR) with a sideband tag.
// Latency: AMT_W cycles from input handshake to out_valid (5 at DATA_WIDTH=32); 1 op/cycle.
// Backpressure: combinational ready chain from out_ready, bubbles collapse; in_ready is low during flush.
//
// Ports:
//   clk, resetn          : clock, async active-low reset
//   flush                : discard every in-flight operation at the next edge
//   in_valid/in_ready    : input handshake; in_data, in_amt, in_op, in_tag carry the operation
//   out_valid/out_ready  : output handshake; out_data, out_tag carry the result
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  localparam int AMT_W     = amt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0]      in_amt,
  input  logic [1:0]            in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int L = AMT_W;

  // Index 0 is the block input, index k+1 is the register of level k.
  logic [L:0]            valid_chain;
  logic [L:0]            ready_chain;
  logic [DATA_WIDTH-1:0] data_chain [0:L];
  logic [AMT_W-1:0]      amt_chain  [0:L];
  logic [1:0]            op_chain   [0:L];
  logic [TAG_WIDTH-1:0]  tag_chain  [0:L];

  assign valid_chain[0] = in_valid;
  assign data_chain[0]  = in_data;
  assign amt_chain[0]   = in_amt;
  assign op_chain[0]    = in_op;
  assign tag_chain[0]   = in_tag;
  assign ready_chain[L] = out_ready;

  for (genvar k = 0; k < L; k++) begin : g_stage
    shifter_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .LEVEL      (k)
    ) u_stage (
      .clk        (clk),
      .resetn     (resetn),
      .flush      (flush),
      .up_valid   (valid_chain[k]),
      .up_ready   (ready_chain[k]),
      .up_data    (data_chain[k]),
      .up_amt     (amt_chain[k]),
      .up_op      (op_chain[k]),
      .up_tag     (tag_chain[k]),
      .down_ready (ready_chain[k+1]),
      .valid      (valid_chain[k+1]),
      .data       (data_chain[k+1]),
      .amt        (amt_chain[k+1]),
      .op         (op_chain[k+1]),
      .tag        (tag_chain[k+1])
    );
  end

  // Stage 0 sees in_valid directly; blocking in_ready during flush is what
  // keeps a flush-cycle input from counting as accepted.
  assign in_ready  = ready_chain[0] && !flush;

  assign out_valid = valid_chain[L];
  assign out_data  = data_chain[L];
  assign out_tag   = tag_chain[L];

  // The last level's amount and op have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_chain[L], op_chain[L]};

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, fully pipelined logarithmic barrel shifter: one pipeline register per shift level; throughput of one operation per cycle.
- Supports SLL, SRL, SRA and a new rotate-right mode.
- Valid/ready handshakes on input and output, with a sideband tag carried alongside each operation.
- Sits between the issue logic and writeback in the next-generation CPU datapath, replacing the single-cycle combinational shifter where timing requires it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be a power of two, at least 8.
- TAG_WIDTH, 4, width of the sideband tag carried unchanged with each operation; must be at least 1.
- AMT_W, $clog2(DATA_WIDTH), derived (localparam): shift-amount width; also the number of levels L.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous: discards all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  the block accepts the operation this cycle.
- in_data  in  DATA_WIDTH  operand A.
- in_amt  in  AMT_W  shift amount B (unsigned).
- in_op  in  2  operation: 00 SLL, 10 SRL, 11 SRA, 01 ROR.
- in_tag  in  TAG_WIDTH  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  shifted result.
- out_tag  out  TAG_WIDTH  tag of the result.

Behaviour:
- Pipeline structure
  - L = AMT_W stages. Stage k register holds: valid v[k], data, remaining amount bits, op, tag.
  - Stage k applies a shift of 2^k when amount bit k is 1; otherwise data passes through unchanged.
  - The level-0 shift is combinational on the in_* ports and captured into stage 0.
  - out_* is driven directly from stage L-1. Latency is exactly L cycles from handshake to out_valid when there is no backpressure (5 cycles at DATA_WIDTH=32).
- Per-level operations
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the current data MSB. This equals the original sign bit at every level.
  - ROR: bits shifted out at the LSB re-enter at the MSB.
  - Amount 0 passes data unchanged for every op. There is no overflow case; the amount is modulo DATA_WIDTH by construction.
- Handshake
  - rdy[L] = out_ready; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[0] && !flush.
  - This is a combinational ready chain, so bubbles collapse.
  - Stage k loads from stage k-1 (or from the input for k=0) when rdy[k] is 1.
  - v[k] becomes the upstream valid-and-fire; otherwise stage k holds.
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_tag are held stable and no accepted operation is lost or duplicated.
  - in_ready may be 1 while the pipeline is full, provided out_ready is 1 (simultaneous push/pop).
- flush: at the next edge every v[k] clears. Data registers may keep stale values. Any input presented in the flush cycle is not accepted (in_ready=0).
- Reset (resetn=0): asynchronously clears every v[k] and every data, op, amount and tag register to 0.
  - Outputs during reset: out_valid=0, out_data=0, out_tag=0.
  - in_ready is 1 one cycle after reset deassertion once resetn is high; combinationally it equals !flush.
  - Reset mid-operation drops all in-flight operations with no partial output.
- Ordering: results leave in acceptance order; the tag is never modified.

Decomposition:
- Shared package shifter_pkg:
  - op encoding constants SHOP_SLL=2'b00, SHOP_ROR=2'b01, SHOP_SRL=2'b10, SHOP_SRA=2'b11.
  - a helper function computing the AMT_W width.
- Sub-module shifter_stage, instantiated once per level via generate, parameters DATA_WIDTH, TAG_WIDTH, LEVEL. It contains:
  - the single-level mux (shift by 2^LEVEL per op);
  - the stage register with asynchronous active-low reset;
  - the local rdy/v logic.
- The top-level module only chains the stages and drives the ports.

Test Plan:
- SLL: in_data=0x8000_0001, amt=1, op=00, tag=3, out_ready=1 -> after 5 cycles out_data=0x0000_0002, out_tag=3.
- SRA vs SRL: push 0x8000_0000 amt=31, op=11 then the same with op=10 on back-to-back cycles -> 0xFFFF_FFFF then 0x0000_0001 on consecutive cycles.
- ROR: 0x1234_5678, amt=8, op=01 -> 0x7812_3456; amt=0 for all four ops -> data unchanged.
- Backpressure: stream tags 0..9 with out_ready low for cycles 7..12.
  - in_ready drops once 5 ops are queued.
  - out_data is stable while stalled.
  - All 10 results arrive in order with correct values; none are lost.
- Flush and reset:
  - Assert flush with 3 ops in flight -> no out_valid afterwards; the input offered during the flush cycle is not accepted.
  - Pull resetn low mid-stream -> out_valid, out_data and out_tag read 0 immediately, before any clock edge.
- Randomised: 10k random data/amt/op with random in_valid/out_ready against a reference model. DATA_WIDTH=8 and DATA_WIDTH=64 regressions pass.
